// File: rtl/spike_rate_decoder.sv
// -----------------------------------------------------------------------------
// spike_rate_decoder
//
// Receives a 1-bit spike train from an LIF neuron and decodes it over a
// programmable window of N clock cycles into two numeric values: a rate code
// (spike count in the window) and a latency code (index of the first spiking
// cycle in the window).
//
// Ports:
//   clk      system clock, all state on rising edge
//   rst_n    asynchronous active-low reset
//   ena      global enable; low freezes all state and ignores inputs
//   spike    spike train, sampled on each enabled window edge E1..EN
//   win_len  window length N, latched when a window starts
//   start    begin a window (accepted only in IDLE)
//   stop     abort current window / end continuous mode
//   cont     re-arm automatically after each window (sampled at window end)
//   busy     high while a window is being counted
//   rate     spike count of the last completed window (saturating)
//   ttfs     first spiking index (1..N) of the last completed window, 0 = none
//   sat      last completed window's count saturated
//   valid    one-enabled-cycle pulse: rate/ttfs/sat just updated
// -----------------------------------------------------------------------------
module spike_rate_decoder #(
    parameter int CNT_W = 8,
    parameter int WIN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             spike,
    input  logic [WIN_W-1:0] win_len,
    input  logic             start,
    input  logic             stop,
    input  logic             cont,
    output logic             busy,
    output logic [CNT_W-1:0] rate,
    output logic [WIN_W-1:0] ttfs,
    output logic             sat,
    output logic             valid
);

    typedef enum logic {IDLE, COUNT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [WIN_W-1:0] IDX_ONE = 1;

    state_t           state;
    logic [WIN_W-1:0] n_len;    // latched window length
    logic [WIN_W-1:0] idx;      // window edges sampled so far
    logic [WIN_W-1:0] first;    // first spiking index, 0 = none yet
    logic [CNT_W-1:0] cnt;
    logic             sat_int;

    logic [WIN_W-1:0] idx_nx;
    logic [WIN_W-1:0] first_nx;
    logic [CNT_W-1:0] cnt_nx;
    logic             sat_nx;
    logic             last;
    logic             launch;
    logic             rearm;

    // Next values of the window internals including this edge's sample.
    // idx never exceeds N-1 before this increment, so it cannot wrap.
    always_comb begin
        idx_nx   = idx + IDX_ONE;
        cnt_nx   = cnt;
        sat_nx   = sat_int;
        first_nx = first;
        if (spike) begin
            if (cnt == CNT_MAX) sat_nx = 1'b1;
            else                cnt_nx = cnt + CNT_ONE;
            // Indices start at 1, so 0 safely means "no spike yet".
            if (first == '0) first_nx = idx_nx;
        end
        last   = (idx_nx == n_len);
        launch = start & ~stop & (win_len != '0);
        rearm  = cont  & ~stop & (win_len != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            n_len   <= '0;
            idx     <= '0;
            first   <= '0;
            cnt     <= '0;
            sat_int <= 1'b0;
            busy    <= 1'b0;
            rate    <= '0;
            ttfs    <= '0;
            sat     <= 1'b0;
            valid   <= 1'b0;
        end else if (ena) begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    // Spike on the launch edge (E0) is deliberately not counted.
                    if (launch) begin
                        state   <= COUNT;
                        busy    <= 1'b1;
                        n_len   <= win_len;
                        idx     <= '0;
                        first   <= '0;
                        cnt     <= '0;
                        sat_int <= 1'b0;
                    end
                end
                COUNT: begin
                    if (last) begin
                        // Result is published even if stop arrives on EN.
                        rate  <= cnt_nx;
                        ttfs  <= first_nx;
                        sat   <= sat_nx;
                        valid <= 1'b1;
                        if (rearm) begin
                            // EN doubles as E0 of the next window.
                            n_len   <= win_len;
                            idx     <= '0;
                            first   <= '0;
                            cnt     <= '0;
                            sat_int <= 1'b0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        idx     <= idx_nx;
                        cnt     <= cnt_nx;
                        first   <= first_nx;
                        sat_int <= sat_nx;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// -----------------------------------------------------------------------------
// tb_spike_rate_decoder
//
// Directed bench for spike_rate_decoder. Two instances share all inputs: one
// with CNT_W=8 and one with CNT_W=4 to exercise counter saturation. Inputs are
// changed 1 ns after a rising edge, outputs are checked after that as well.
// -----------------------------------------------------------------------------
module tb_spike_rate_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       spike;
    logic [7:0] win_len;
    logic       start;
    logic       stop;
    logic       cont;

    logic       busy,  busy4;
    logic [7:0] rate;
    logic [3:0] rate4;
    logic [7:0] ttfs,  ttfs4;
    logic       sat,   sat4;
    logic       valid, valid4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    spike_rate_decoder #(.CNT_W(8), .WIN_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .spike(spike), .win_len(win_len),
        .start(start), .stop(stop), .cont(cont),
        .busy(busy), .rate(rate), .ttfs(ttfs), .sat(sat), .valid(valid)
    );

    spike_rate_decoder #(.CNT_W(4), .WIN_W(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .spike(spike), .win_len(win_len),
        .start(start), .stop(stop), .cont(cont),
        .busy(busy4), .rate(rate4), .ttfs(ttfs4), .sat(sat4), .valid(valid4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch edge E0 (spike low, not counted anyway), start released after.
    task automatic launch(input logic [7:0] len);
        win_len = len;
        start   = 1'b1;
        spike   = 1'b0;
        tick();
        start   = 1'b0;
    endtask

    // Drive spike = pat[i] on enabled edge i+1, for n edges.
    task automatic feed(input logic [31:0] pat, input int n);
        for (int i = 0; i < n; i++) begin
            spike = pat[i];
            tick();
        end
        spike = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; spike = 1'b0; win_len = 8'd0;
        start = 1'b0; stop = 1'b0; cont = 1'b0;
        #2;
        chk("rst_rate",  rate,  0);
        chk("rst_ttfs",  ttfs,  0);
        chk("rst_sat",   sat,   0);
        chk("rst_valid", valid, 0);
        chk("rst_busy",  busy,  0);
        #10 rst_n = 1'b1;
        tick();

        // Window of 10, spike held high throughout.
        launch(8'd10);
        chk("a_busy_e0", busy, 1);
        spike = 1'b1;
        for (int i = 1; i < 10; i++) tick();
        chk("a_novalid_e9", valid, 0);
        tick();
        spike = 1'b0;
        chk("a_valid", valid, 1);
        chk("a_rate",  rate,  10);
        chk("a_ttfs",  ttfs,  1);
        chk("a_sat",   sat,   0);
        chk("a_busy",  busy,  0);
        tick();
        chk("a_valid_drop", valid, 0);

        // Window of 8, spikes on cycles 4 and 7.
        launch(8'd8);
        feed(32'h48, 8);
        chk("b_valid", valid, 1);
        chk("b_rate",  rate,  2);
        chk("b_ttfs",  ttfs,  4);
        // Same length, no spikes.
        launch(8'd8);
        feed(32'h0, 8);
        chk("b0_valid", valid, 1);
        chk("b0_rate",  rate,  0);
        chk("b0_ttfs",  ttfs,  0);

        // Window of 20, all spikes: 4-bit counter saturates.
        launch(8'd20);
        feed(32'hFFFFF, 20);
        chk("c_rate4", rate4, 15);
        chk("c_sat4",  sat4,  1);
        chk("c_ttfs4", ttfs4, 1);
        chk("c_rate8", rate,  20);
        chk("c_sat8",  sat,   0);

        // Continuous mode, win_len 5, pattern 1,0,1,0,1,0,1,0,1,0.
        cont = 1'b1;
        launch(8'd5);
        feed(32'h15, 5);
        chk("d1_valid", valid, 1);
        chk("d1_rate",  rate,  3);
        chk("d1_ttfs",  ttfs,  1);
        chk("d1_busy",  busy,  1);
        feed(32'h0A, 5);
        chk("d2_valid", valid, 1);
        chk("d2_rate",  rate,  2);
        chk("d2_ttfs",  ttfs,  2);
        chk("d2_busy",  busy,  1);
        stop = 1'b1; cont = 1'b0;
        tick();
        stop = 1'b0;
        chk("d_stop_busy",  busy,  0);
        chk("d_stop_valid", valid, 0);
        chk("d_stop_rate",  rate,  2);

        // Abort at cycle 3 of a 10-cycle window.
        launch(8'd10);
        feed(32'h3, 2);
        stop = 1'b1; spike = 1'b1;
        tick();
        stop = 1'b0; spike = 1'b0;
        chk("e_busy",  busy,  0);
        chk("e_valid", valid, 0);
        feed(32'h0, 10);
        chk("e_novalid", valid, 0);
        chk("e_rate",    rate,  2);
        chk("e_ttfs",    ttfs,  2);

        // Start with zero length, and start together with stop.
        launch(8'd0);
        chk("f_zero_len_busy", busy, 0);
        stop = 1'b1;
        launch(8'd4);
        stop = 1'b0;
        chk("f_start_stop_busy", busy, 0);

        // Freeze for 4 cycles mid-window; spikes during freeze are ignored.
        launch(8'd6);
        feed(32'h1, 2);
        ena = 1'b0; spike = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("g_frozen_busy",  busy,  1);
        chk("g_frozen_valid", valid, 0);
        ena = 1'b1;
        feed(32'h4, 3);
        chk("g_e5_novalid", valid, 0);
        feed(32'h0, 1);
        chk("g_valid", valid, 1);
        chk("g_rate",  rate,  2);
        chk("g_ttfs",  ttfs,  1);
        ena = 1'b0;
        tick();
        chk("g_valid_held", valid, 1);
        ena = 1'b1;
        tick();
        chk("g_valid_drop", valid, 0);

        // Stop on the final edge still publishes.
        launch(8'd3);
        feed(32'h3, 2);
        stop = 1'b1; spike = 1'b1;
        tick();
        stop = 1'b0; spike = 1'b0;
        chk("h_valid", valid, 1);
        chk("h_rate",  rate,  3);
        chk("h_busy",  busy,  0);

        // Asynchronous reset mid-window, between edges.
        launch(8'd10);
        feed(32'h3, 2);
        #3 rst_n = 1'b0;
        #1;
        chk("i_rate",  rate,  0);
        chk("i_busy",  busy,  0);
        chk("i_valid", valid, 0);
        chk("i_ttfs",  ttfs,  0);
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
- Consumer end of the neuron spike interface: receives the 1-bit spike train from an LIF neuron and decodes it back into numeric values.
- Decodes over a programmable window of N clock cycles, producing two values:
  - rate code: the spike count in the window.
  - latency code: the time-to-first-spike in the window.
- Sits downstream of a neuron (or neuron array output mux) so spiking activity can be read back as an 8-bit-style value on the output pins.

Parameters:
- CNT_W, 8, width of the spike counter / rate output; saturates at 2^CNT_W-1.
- WIN_W, 8, width of window length and ttfs; max window 2^WIN_W-1 cycles.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- ena  input  1  global enable; low freezes all state and ignores inputs.
- spike  input  1  spike train from neuron, sampled each enabled cycle.
- win_len  input  WIN_W  window length N in cycles; latched on start.
- start  input  1  begin a window (accepted only in IDLE).
- stop  input  1  abort current window / clear continuous mode.
- cont  input  1  continuous mode: re-arm automatically after each window; sampled at window end.
- busy  output  1  high while in COUNT.
- rate  output  CNT_W  spike count of the last completed window.
- ttfs  output  WIN_W  index (1..N) of the first spiking cycle of the last completed window; 0 = no spike.
- sat  output  1  last completed window's count saturated.
- valid  output  1  one-cycle pulse: rate/ttfs/sat just updated.

Behaviour:
- Reset (rst_n low, async):
  - state IDLE.
  - rate=0, ttfs=0, sat=0, valid=0, busy=0.
  - Internal counters and latched length cleared.
- Enable:
  - All behaviour below applies only on edges where ena=1.
  - ena=0: everything holds.
  - valid is registered, so a valid pulse that is high stays high until the next enabled edge.
- States:
  - IDLE:
    - start=1 & stop=0 & win_len!=0 → COUNT.
    - On that edge (E0): latch N=win_len, clear cnt, idx, first-spike register, sat_int.
    - Spike on the E0 edge is NOT counted.
    - start with win_len=0 is ignored (stay IDLE).
    - start & stop together: stop wins.
  - COUNT:
    - Edges E1..EN each sample spike.
    - idx increments 1..N.
    - If spike=1: cnt increments, saturating at 2^CNT_W-1; sat_int set if an increment is attempted at max.
    - If spike=1 and no spike yet this window: first-spike register <= idx.
    - start is ignored; win_len changes are ignored until the next window.
  - Window end at EN:
    - rate <= final cnt (including the EN sample).
    - ttfs <= first index, or 0 if none.
    - sat <= sat_int.
    - valid=1 for the cycle after EN.
    - If cont=1 & stop=0: EN also acts as E0 of the next window. Re-latch win_len; a zero value → IDLE. Internals clear, giving back-to-back windows with no gap.
    - Otherwise → IDLE.
  - stop=1 in COUNT:
    - → IDLE immediately.
    - No valid pulse; rate/ttfs/sat keep the previous result.
    - stop on the EN edge itself: the result is still published (valid=1), then IDLE.
- Arithmetic: counters unsigned; no wrap-around anywhere (cnt saturates, idx bounded by N ≤ 2^WIN_W-1).
- busy = (state==COUNT), registered.
- Async reset mid-window: immediate return to reset values; no valid.
- Outputs are registered.
- Decoding latency: result is visible N cycles after the start edge.

Test Plan:
- Reset: assert rst_n=0 mid-cycle → rate=0, ttfs=0, sat=0, valid=0, busy=0 without a clock edge.
- win_len=10, start pulse, spike held 1 for 10 cycles → valid pulses once at the 10th edge after start, rate=10, ttfs=1, sat=0, busy falls same edge.
- win_len=8, spike high only on window cycles 4 and 7 → rate=2, ttfs=4; then a repeat with no spikes → rate=0, ttfs=0.
- CNT_W=4, win_len=20, spike constant 1 → rate=15, sat=1, ttfs=1.
- cont=1, win_len=5, spike pattern 1,0,1,0,1,0,1,0,1,0:
  - first window: valid with rate=3, ttfs=1.
  - second window: valid 5 edges later with rate=2, ttfs=2.
  - then stop → IDLE after the current window is aborted.
- Abort/edge cases:
  - stop at cycle 3 of a 10-cycle window → no valid, rate/ttfs unchanged.
  - start with win_len=0 → busy stays 0.
  - ena=0 for 4 cycles mid-window → window stretches by 4 cycles, count unchanged by spikes during the freeze.
